timer_sfr_ctrl: RTL and testbench

- SFR-side front end for the two Timer instances (T0, T1).
- Holds TCON, TMOD, TH0, TL0, TH1 and TL1, and serves CPU SFR reads and writes.
- Synchronises the T0/T1 count pins and the INT0/INT1 pins.
- Generates each core's run enable (t_s), loads back the cores' next-count bytes, latches overflow into TF0/TF1, and produces the four TCON interrupt request flags for the interrupt controller.

---
 rtl/timer_pkg.sv | 41 ++++
 rtl/timer_chan_regs.sv | 100 ++++++++++
 rtl/timer_sfr_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_timer_sfr_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer SFR front end: SFR addresses, TCON and
// TMOD bit positions, mode encodings, and the rule for when TH is frozen.
package timer_pkg;

  localparam logic [7:0] ADDR_TCON = 8'h88;
  localparam logic [7:0] ADDR_TMOD = 8'h89;
  localparam logic [7:0] ADDR_TL0  = 8'h8A;
  localparam logic [7:0] ADDR_TL1  = 8'h8B;
  localparam logic [7:0] ADDR_TH0  = 8'h8C;
  localparam logic [7:0] ADDR_TH1  = 8'h8D;

  localparam int TCON_TF1 = 7;
  localparam int TCON_TR1 = 6;
  localparam int TCON_TF0 = 5;
  localparam int TCON_TR0 = 4;
  localparam int TCON_IE1 = 3;
  localparam int TCON_IT1 = 2;
  localparam int TCON_IE0 = 1;
  localparam int TCON_IT0 = 0;

  localparam int TMOD_GATE = 3;
  localparam int TMOD_CT   = 2;
  localparam int TMOD_M1   = 1;
  localparam int TMOD_M0   = 0;

  typedef enum logic [1:0] {
    M13    = 2'b00,
    M16    = 2'b01,
    M8R    = 2'b10,
    MSPLIT = 2'b11
  } tmode_e;

  // TH is not loaded from the core in auto-reload timer mode (it holds the
  // reload value) and in split/stop mode.
  function automatic logic th_frozen(input logic [3:0] tmod);
    tmode_e mode;
    mode = tmode_e'({tmod[TMOD_M1], tmod[TMOD_M0]});
    return (mode == MSPLIT) || ((mode == M8R) && !tmod[TMOD_CT]);
  endfunction

endpackage

// File: rtl/timer_chan_regs.sv
// Per-timer register slice: TH/TL count bytes, post-write hold flag,
// overflow edge detect into TF, and the run enable.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   tmod                  {GATE, C/T, M1, M0} for this timer
//   tr, int_sync          run bit and synchronised INTx level
//   we_th, we_tl, wdata   CPU byte writes
//   th_nxt, tl_nxt        next-count bytes from the core
//   t_o                   core overflow level
//   tf_we, tf_wval        CPU write of the TF bit via TCON
//   ack_tf                interrupt acknowledge
//   th, tl, t_s, tf       count bytes, run enable, overflow flag
module timer_chan_regs
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] tmod,
  input  logic       tr,
  input  logic       int_sync,
  input  logic       we_th,
  input  logic       we_tl,
  input  logic [7:0] wdata,
  input  logic [7:0] th_nxt,
  input  logic [7:0] tl_nxt,
  input  logic       t_o,
  input  logic       tf_we,
  input  logic       tf_wval,
  input  logic       ack_tf,
  output logic [7:0] th,
  output logic [7:0] tl,
  output logic       t_s,
  output logic       tf
);

  logic [7:0] th_q, th_d;
  logic [7:0] tl_q, tl_d;
  logic       hold_q, hold_d;
  logic       t_o_q, t_o_d;
  logic       t_s_q, t_s_d;
  logic       tf_q, tf_d;
  logic       ovf_edge;

  assign t_s = tr & (~tmod[TMOD_GATE] | int_sync);
  assign th  = th_q;
  assign tl  = tl_q;
  assign tf  = tf_q;

  always_comb begin
    th_d     = th_q;
    tl_d     = tl_q;
    hold_d   = we_th | we_tl;
    t_o_d    = t_o;
    t_s_d    = t_s;
    tf_d     = tf_q;
    // Only count an overflow rise if the timer was actually running.
    ovf_edge = t_o & ~t_o_q & t_s_q;

    // The core's next value in the cycle after a CPU write was computed from
    // the old count, so it is dropped.
    if (we_tl) begin
      tl_d = wdata;
    end else if (!hold_q) begin
      tl_d = tl_nxt;
    end

    if (we_th) begin
      th_d = wdata;
    end else if (!hold_q && !th_frozen(tmod)) begin
      th_d = th_nxt;
    end

    if (ovf_edge) begin
      tf_d = 1'b1;
    end else if (tf_we) begin
      tf_d = tf_wval;
    end else if (ack_tf) begin
      tf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      th_q   <= '0;
      tl_q   <= '0;
      hold_q <= 1'b0;
      t_o_q  <= 1'b0;
      t_s_q  <= 1'b0;
      tf_q   <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      hold_q <= hold_d;
      t_o_q  <= t_o_d;
      t_s_q  <= t_s_d;
      tf_q   <= tf_d;
    end
  end

endmodule

// File: rtl/timer_sfr_ctrl.sv
// SFR front end for timers T0/T1: holds TCON/TMOD/TH0/TL0/TH1/TL1, serves
// CPU reads/writes, synchronises count and interrupt pins, and produces the
// run enables and the TF/IE interrupt request flags.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   sfr_addr/we/wdata/rdata/hit     CPU SFR bus (read is combinational)
//   t0_pin, t1_pin, int0_n, int1_n  asynchronous pins
//   thX_nxt, tlX_nxt, tX_o          next-count bytes and overflow from cores
//   thX, tlX, tmodX, tX_s           count bytes, mode fields, run enables
//   cntX_sig                        synchronised count pins
//   tf0, tf1, ie0, ie1, ack_*       interrupt flags and acknowledges
module timer_sfr_ctrl
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sfr_addr,
  input  logic       sfr_we,
  input  logic [7:0] sfr_wdata,
  output logic [7:0] sfr_rdata,
  output logic       sfr_hit,
  input  logic       t0_pin,
  input  logic       t1_pin,
  input  logic       int0_n,
  input  logic       int1_n,
  input  logic [7:0] th0_nxt,
  input  logic [7:0] tl0_nxt,
  input  logic [7:0] th1_nxt,
  input  logic [7:0] tl1_nxt,
  input  logic       t0_o,
  input  logic       t1_o,
  output logic [7:0] th0,
  output logic [7:0] tl0,
  output logic [7:0] th1,
  output logic [7:0] tl1,
  output logic [3:0] tmod0,
  output logic [3:0] tmod1,
  output logic       t0_s,
  output logic       t1_s,
  output logic       cnt0_sig,
  output logic       cnt1_sig,
  output logic       tf0,
  output logic       tf1,
  output logic       ie0,
  output logic       ie1,
  input  logic       ack_tf0,
  input  logic       ack_tf1,
  input  logic       ack_ie0,
  input  logic       ack_ie1
);

  // Pin order in the synchroniser vectors: {int1_n, int0_n, t1_pin, t0_pin}
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [1:0] int_dly_q, int_dly_d;
  logic [1:0] tr_q, tr_d;
  logic [1:0] it_q, it_d;
  logic [1:0] ie_q, ie_d;
  logic [7:0] tmod_q, tmod_d;
  logic [1:0] int_sync;
  logic [1:0] ack_ie;
  logic       wr_tcon, wr_tmod, wr_tl0, wr_tl1, wr_th0, wr_th1;

  assign wr_tcon = sfr_we && (sfr_addr == ADDR_TCON);
  assign wr_tmod = sfr_we && (sfr_addr == ADDR_TMOD);
  assign wr_tl0  = sfr_we && (sfr_addr == ADDR_TL0);
  assign wr_tl1  = sfr_we && (sfr_addr == ADDR_TL1);
  assign wr_th0  = sfr_we && (sfr_addr == ADDR_TH0);
  assign wr_th1  = sfr_we && (sfr_addr == ADDR_TH1);

  assign int_sync = sync2_q[3:2];
  assign ack_ie   = {ack_ie1, ack_ie0};
  assign cnt0_sig = sync2_q[0];
  assign cnt1_sig = sync2_q[1];
  assign tmod0    = tmod_q[3:0];
  assign tmod1    = tmod_q[7:4];
  assign ie0      = ie_q[0];
  assign ie1      = ie_q[1];

  always_comb begin
    sync1_d   = {int1_n, int0_n, t1_pin, t0_pin};
    sync2_d   = sync1_q;
    int_dly_d = int_sync;
    tr_d      = tr_q;
    it_d      = it_q;
    tmod_d    = tmod_q;
    ie_d      = ie_q;

    if (wr_tcon) begin
      tr_d = {sfr_wdata[TCON_TR1], sfr_wdata[TCON_TR0]};
      it_d = {sfr_wdata[TCON_IT1], sfr_wdata[TCON_IT0]};
    end
    if (wr_tmod) begin
      tmod_d = sfr_wdata;
    end

    for (int x = 0; x < 2; x++) begin
      if (it_q[x]) begin
        if (int_dly_q[x] && !int_sync[x]) begin
          ie_d[x] = 1'b1;
        end else if (ack_ie[x] || wr_tcon) begin
          ie_d[x] = 1'b0;
        end
      end else begin
        // Level mode simply mirrors the pin, so acks/writes cannot stick.
        ie_d[x] = ~int_sync[x];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      int_dly_q <= '0;
      tr_q      <= '0;
      it_q      <= '0;
      ie_q      <= '0;
      tmod_q    <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      int_dly_q <= int_dly_d;
      tr_q      <= tr_d;
      it_q      <= it_d;
      ie_q      <= ie_d;
      tmod_q    <= tmod_d;
    end
  end

  timer_chan_regs u_chan0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .tmod     (tmod_q[3:0]),
    .tr       (tr_q[0]),
    .int_sync (int_sync[0]),
    .we_th    (wr_th0),
    .we_tl    (wr_tl0),
    .wdata    (sfr_wdata),
    .th_nxt   (th0_nxt),
    .tl_nxt   (tl0_nxt),
    .t_o      (t0_o),
    .tf_we    (wr_tcon),
    .tf_wval  (sfr_wdata[TCON_TF0]),
    .ack_tf   (ack_tf0),
    .th       (th0),
    .tl       (tl0),
    .t_s      (t0_s),
    .tf       (tf0)
  );

  timer_chan_regs u_chan1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .tmod     (tmod_q[7:4]),
    .tr       (tr_q[1]),
    .int_sync (int_sync[1]),
    .we_th    (wr_th1),
    .we_tl    (wr_tl1),
    .wdata    (sfr_wdata),
    .th_nxt   (th1_nxt),
    .tl_nxt   (tl1_nxt),
    .t_o      (t1_o),
    .tf_we    (wr_tcon),
    .tf_wval  (sfr_wdata[TCON_TF1]),
    .ack_tf   (ack_tf1),
    .th       (th1),
    .tl       (tl1),
    .t_s      (t1_s),
    .tf       (tf1)
  );

  always_comb begin
    sfr_rdata = '0;
    sfr_hit   = 1'b1;
    case (sfr_addr)
      ADDR_TCON: sfr_rdata = {tf1, tr_q[1], tf0, tr_q[0], ie_q[1], it_q[1], ie_q[0], it_q[0]};
      ADDR_TMOD: sfr_rdata = tmod_q;
      ADDR_TL0:  sfr_rdata = tl0;
      ADDR_TL1:  sfr_rdata = tl1;
      ADDR_TH0:  sfr_rdata = th0;
      ADDR_TH1:  sfr_rdata = th1;
      default:   sfr_hit   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_timer_sfr_ctrl.sv
module tb_timer_sfr_ctrl;

  logic       clk, rst_n;
  logic [7:0] sfr_addr, sfr_wdata, sfr_rdata;
  logic       sfr_we, sfr_hit;
  logic       t0_pin, t1_pin, int0_n, int1_n;
  logic [7:0] th0_nxt, tl0_nxt, th1_nxt, tl1_nxt;
  logic       t0_o, t1_o;
  logic [7:0] th0, tl0, th1, tl1;
  logic [3:0] tmod0, tmod1;
  logic       t0_s, t1_s, cnt0_sig, cnt1_sig, tf0, tf1, ie0, ie1;
  logic       ack_tf0, ack_tf1, ack_ie0, ack_ie1;

  int n_tests = 0;
  int n_fail  = 0;

  timer_sfr_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .sfr_addr(sfr_addr), .sfr_we(sfr_we), .sfr_wdata(sfr_wdata),
    .sfr_rdata(sfr_rdata), .sfr_hit(sfr_hit),
    .t0_pin(t0_pin), .t1_pin(t1_pin), .int0_n(int0_n), .int1_n(int1_n),
    .th0_nxt(th0_nxt), .tl0_nxt(tl0_nxt), .th1_nxt(th1_nxt), .tl1_nxt(tl1_nxt),
    .t0_o(t0_o), .t1_o(t1_o),
    .th0(th0), .tl0(tl0), .th1(th1), .tl1(tl1),
    .tmod0(tmod0), .tmod1(tmod1), .t0_s(t0_s), .t1_s(t1_s),
    .cnt0_sig(cnt0_sig), .cnt1_sig(cnt1_sig),
    .tf0(tf0), .tf1(tf1), .ie0(ie0), .ie1(ie1),
    .ack_tf0(ack_tf0), .ack_tf1(ack_tf1), .ack_ie0(ack_ie0), .ack_ie1(ack_ie1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (indices: timer 0/1; pins {int1_n,int0_n,t1_pin,t0_pin})
  logic [7:0] m_th [2];
  logic [7:0] m_tl [2];
  logic [1:0] m_hold, m_tr, m_it, m_tf, m_ie, m_prev_to, m_prev_ts, m_prev_int;
  logic [7:0] m_tmod;
  logic [3:0] m_p1, m_p2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ts(input int x);
    return m_tr[x] & (~m_tmod[4*x+3] | m_p2[2+x]);
  endfunction

  function automatic logic [8:0] m_read(input logic [7:0] a);
    case (a)
      8'h88: return {1'b1, m_tf[1], m_tr[1], m_tf[0], m_tr[0], m_ie[1], m_it[1], m_ie[0], m_it[0]};
      8'h89: return {1'b1, m_tmod};
      8'h8A: return {1'b1, m_tl[0]};
      8'h8B: return {1'b1, m_tl[1]};
      8'h8C: return {1'b1, m_th[0]};
      8'h8D: return {1'b1, m_th[1]};
      default: return 9'h000;
    endcase
  endfunction

  task automatic model_step();
    logic [1:0] ts, tov, ackt, acki, wth, wtl;
    logic [7:0] thn [2];
    logic [7:0] tln [2];
    logic       wtcon;
    logic [1:0] mode;
    logic       frozen;
    if (!rst_n) begin
      m_th[0] = 0; m_th[1] = 0; m_tl[0] = 0; m_tl[1] = 0;
      m_hold = 0; m_tr = 0; m_it = 0; m_tf = 0; m_ie = 0; m_tmod = 0;
      m_prev_to = 0; m_prev_ts = 0; m_prev_int = 0; m_p1 = 0; m_p2 = 0;
      return;
    end
    ts    = {m_ts(1), m_ts(0)};
    tov   = {t1_o, t0_o};
    ackt  = {ack_tf1, ack_tf0};
    acki  = {ack_ie1, ack_ie0};
    thn[0] = th0_nxt; thn[1] = th1_nxt; tln[0] = tl0_nxt; tln[1] = tl1_nxt;
    wtcon = sfr_we && sfr_addr == 8'h88;
    wtl   = {sfr_we && sfr_addr == 8'h8B, sfr_we && sfr_addr == 8'h8A};
    wth   = {sfr_we && sfr_addr == 8'h8D, sfr_we && sfr_addr == 8'h8C};
    for (int x = 0; x < 2; x++) begin
      if (tov[x] && !m_prev_to[x] && m_prev_ts[x]) m_tf[x] = 1'b1;
      else if (wtcon) m_tf[x] = sfr_wdata[5 + 2*x];
      else if (ackt[x]) m_tf[x] = 1'b0;
      if (m_it[x]) begin
        if (m_prev_int[x] && !m_p2[2+x]) m_ie[x] = 1'b1;
        else if (acki[x] || wtcon) m_ie[x] = 1'b0;
      end else begin
        m_ie[x] = ~m_p2[2+x];
      end
      mode   = {m_tmod[4*x+1], m_tmod[4*x]};
      frozen = (mode == 2'b11) || (mode == 2'b10 && !m_tmod[4*x+2]);
      if (wtl[x]) m_tl[x] = sfr_wdata;
      else if (!m_hold[x]) m_tl[x] = tln[x];
      if (wth[x]) m_th[x] = sfr_wdata;
      else if (!m_hold[x] && !frozen) m_th[x] = thn[x];
      m_hold[x] = wth[x] | wtl[x];
    end
    m_prev_to  = tov;
    m_prev_ts  = ts;
    m_prev_int = m_p2[3:2];
    m_p2 = m_p1;
    m_p1 = {int1_n, int0_n, t1_pin, t0_pin};
    if (sfr_we && sfr_addr == 8'h89) m_tmod = sfr_wdata;
    if (wtcon) begin
      m_tr = {sfr_wdata[6], sfr_wdata[4]};
      m_it = {sfr_wdata[2], sfr_wdata[0]};
    end
  endtask

  task automatic model_check();
    logic [8:0] rd;
    rd = m_read(sfr_addr);
    chk("th0", th0, m_th[0]);   chk("tl0", tl0, m_tl[0]);
    chk("th1", th1, m_th[1]);   chk("tl1", tl1, m_tl[1]);
    chk("tmod0", tmod0, m_tmod[3:0]); chk("tmod1", tmod1, m_tmod[7:4]);
    chk("t0_s", t0_s, m_ts(0)); chk("t1_s", t1_s, m_ts(1));
    chk("cnt0_sig", cnt0_sig, m_p2[0]); chk("cnt1_sig", cnt1_sig, m_p2[1]);
    chk("tf0", tf0, m_tf[0]); chk("tf1", tf1, m_tf[1]);
    chk("ie0", ie0, m_ie[0]); chk("ie1", ie1, m_ie[1]);
    chk("sfr_rdata", sfr_rdata, rd[7:0]); chk("sfr_hit", sfr_hit, rd[8]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    sfr_addr = a; sfr_wdata = d; sfr_we = 1'b1;
    tick();
    sfr_we = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_hit;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1'b0, 8'h88, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 8'h89, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[2]  = '{1'b0, 8'h8A, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 8'h8B, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[4]  = '{1'b0, 8'h8C, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[5]  = '{1'b0, 8'h8D, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[6]  = '{1'b0, 8'h8A, 1'b1, 8'hFF, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 8'h90, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 8'h89, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[9]  = '{1'b1, 8'h89, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 8'h89, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[11] = '{1'b1, 8'h89, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[12] = '{1'b1, 8'h89, 1'b1, 8'h5A, 8'h5A, 1'b1};
    tbl[13] = '{1'b1, 8'h8B, 1'b1, 8'h77, 8'h77, 1'b1};
    tbl[14] = '{1'b1, 8'h8D, 1'b1, 8'h99, 8'h99, 1'b1};
    tbl[15] = '{1'b1, 8'h8F, 1'b1, 8'h3C, 8'h00, 1'b0};
    tbl[16] = '{1'b1, 8'h89, 1'b0, 8'h00, 8'h5A, 1'b1};
    tbl[17] = '{1'b1, 8'h88, 1'b1, 8'h50, 8'h50, 1'b1};
    tbl[18] = '{1'b1, 8'h89, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[19] = '{1'b1, 8'h88, 1'b1, 8'h00, 8'h00, 1'b1};

    rst_n = 1'b0; sfr_addr = 8'h00; sfr_we = 1'b0; sfr_wdata = 8'h00;
    t0_pin = 1'b0; t1_pin = 1'b0; int0_n = 1'b1; int1_n = 1'b1;
    th0_nxt = 8'h00; tl0_nxt = 8'h00; th1_nxt = 8'h00; tl1_nxt = 8'h00;
    t0_o = 1'b0; t1_o = 1'b0;
    ack_tf0 = 1'b0; ack_tf1 = 1'b0; ack_ie0 = 1'b0; ack_ie1 = 1'b0;

    idle(2);
    chk("rst_tf0", tf0, 1'b0); chk("rst_tf1", tf1, 1'b0);
    chk("rst_ie0", ie0, 1'b0); chk("rst_ie1", ie1, 1'b0);
    chk("rst_t0_s", t0_s, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rst_n = tbl[i].rst; sfr_addr = tbl[i].addr;
      sfr_we = tbl[i].we; sfr_wdata = tbl[i].wdata;
      tick();
      chk("tbl_rdata", sfr_rdata, tbl[i].exp_rdata);
      chk("tbl_hit", sfr_hit, tbl[i].exp_hit);
    end
    sfr_we = 1'b0;

    // Writes, run enable and stale-value hold
    th0_nxt = 8'h55; tl0_nxt = 8'h66;
    wr(8'h8A, 8'h34); chk("hold_tl0_a", tl0, 8'h34);
    wr(8'h8C, 8'h12); chk("hold_tl0_b", tl0, 8'h34); chk("hold_th0_b", th0, 8'h12);
    wr(8'h89, 8'h01); chk("hold_tl0_c", tl0, 8'h34); chk("hold_th0_c", th0, 8'h12);
    wr(8'h88, 8'h10); chk("run_t0_s", t0_s, 1'b1);
    chk("track_tl0", tl0, 8'h66); chk("track_th0", th0, 8'h55);

    // GATE qualification and 2-cycle pin latency
    int0_n = 1'b0;
    wr(8'h89, 8'h09); idle(3); chk("gate_low_t0_s", t0_s, 1'b0);
    int0_n = 1'b1;
    tick(); chk("gate_lat1_t0_s", t0_s, 1'b0);
    tick(); chk("gate_lat2_t0_s", t0_s, 1'b1);
    wr(8'h89, 8'h01);

    // Overflow flag set, ack, and set-beats-ack
    t0_o = 1'b1; tick(); chk("tf0_set", tf0, 1'b1);
    t0_o = 1'b0; ack_tf0 = 1'b1; tick(); ack_tf0 = 1'b0; chk("tf0_ack", tf0, 1'b0);
    t0_o = 1'b1; ack_tf0 = 1'b1; tick(); ack_tf0 = 1'b0; chk("tf0_set_vs_ack", tf0, 1'b1);
    t0_o = 1'b0; ack_tf0 = 1'b1; tick(); ack_tf0 = 1'b0;

    // INT1 edge mode, then level mode
    wr(8'h88, 8'h14);
    int1_n = 1'b0;
    tick(); chk("ie1_edge_c1", ie1, 1'b0);
    tick(); chk("ie1_edge_c2", ie1, 1'b0);
    tick(); chk("ie1_edge_c3", ie1, 1'b1);
    int1_n = 1'b1;
    ack_ie1 = 1'b1; tick(); ack_ie1 = 1'b0; chk("ie1_ack", ie1, 1'b0);
    int1_n = 1'b0; idle(3);
    wr(8'h88, 8'h10); idle(2); chk("ie1_level", ie1, 1'b1);
    ack_ie1 = 1'b1; tick(); ack_ie1 = 1'b0; chk("ie1_level_ack", ie1, 1'b1);
    int1_n = 1'b1; idle(3); chk("ie1_level_hi", ie1, 1'b0);

    // Mode 2: TH holds reload value while TL follows the core
    th0_nxt = 8'h00;
    wr(8'h89, 8'h02);
    wr(8'h8C, 8'hC8);
    tl0_nxt = 8'hA5; idle(3);
    chk("m2_th0_hold", th0, 8'hC8); chk("m2_tl0_follow", tl0, 8'hA5);

    // Reset mid-count
    rst_n = 1'b0; tick(); chk("midrst_t0_s", t0_s, 1'b0); chk("midrst_th0", th0, 8'h00);
    rst_n = 1'b1; tick(); chk("postrst_t0_s", t0_s, 1'b0);

    // Randomized run against the model
    for (int i = 0; i < 2500; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      sfr_we    = ($urandom_range(0, 3) == 0);
      sfr_addr  = 8'(8'h86 + $urandom_range(0, 9));
      sfr_wdata = 8'($urandom);
      th0_nxt = 8'($urandom); tl0_nxt = 8'($urandom);
      th1_nxt = 8'($urandom); tl1_nxt = 8'($urandom);
      if ($urandom_range(0, 3) == 0) t0_o = ~t0_o;
      if ($urandom_range(0, 3) == 0) t1_o = ~t1_o;
      if ($urandom_range(0, 3) == 0) t0_pin = ~t0_pin;
      if ($urandom_range(0, 3) == 0) t1_pin = ~t1_pin;
      if ($urandom_range(0, 4) == 0) int0_n = ~int0_n;
      if ($urandom_range(0, 4) == 0) int1_n = ~int1_n;
      ack_tf0 = ($urandom_range(0, 5) == 0);
      ack_tf1 = ($urandom_range(0, 5) == 0);
      ack_ie0 = ($urandom_range(0, 5) == 0);
      ack_ie1 = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
